bp_clint_multi: RTL
===================

Name: bp_clint_multi

Overview:
- Parametrised core-local interruptor: per-hart msip and mtimecmp, one shared mtime, N harts.
- Decodes the fixed CLINT map: msip at 0x0200_0000 + 4*h, mtimecmp at 0x0200_4000 + 8*h, mtime at 0x0200_bff8.
- Generalises the single-hart map with a hart count, a programmable tick prescaler, 32/64-bit access sizes and error signalling.
- Sits on the I/O side of the coherence network and drives timer and software interrupts into each core's CSR logic.

Parameters:
- num_core_p, 4: number of harts; range 1..64.
- paddr_width_p, 56: physical address width.
- dword_width_p, 64: data width.
- rtc_div_p, 8: clk_i cycles per mtime tick; must be >= 1.
- rtc_div_width_lp, clog2(rtc_div_p)+1: prescaler counter width (derived).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- req_wr_i  in  1  1 = write, 0 = read.
- req_addr_i  in  paddr_width_p  byte address.
- req_size_i  in  1  0 = 4 B, 1 = 8 B.
- req_data_i  in  dword_width_p  write data; for 4 B accesses the low 32 bits are used.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  response consumed.
- resp_data_o  out  dword_width_p  read data; 0 for writes.
- resp_err_o  out  1  unmapped or misaligned access.
- timer_irq_o  out  num_core_p  mtime >= mtimecmp[h].
- soft_irq_o  out  num_core_p  msip[h] bit 0.

Behaviour:
- Reset (async assert, sync deassert assumed by integration): mtime=0; prescaler=0; every mtimecmp=all-ones; every msip=0; FSM=IDLE; resp_v_o=0; resp_data_o=0; resp_err_o=0; timer_irq_o=0; soft_irq_o=0.
- FSM IDLE: req_ready_o=1. On handshake:
  - perform the register access in that cycle;
  - latch the response;
  - go to RESP next cycle.
- FSM RESP: req_ready_o=0; resp_v_o=1; data/err held stable until resp_yumi_i, then return to IDLE.
- One outstanding request. Minimum request-to-response latency is 1 cycle; throughput is 1 request per 2 cycles.
- Decode, msip: addr[15:0] < 4*num_core_p and 4 B aligned; size must be 4 B.
  - Read returns {63'b0, msip}.
  - Write stores data[0].
- Decode, mtimecmp: 0x4000 <= addr[15:0] < 0x4000 + 8*num_core_p.
  - 8 B access: must be 8-aligned; full register.
  - 4 B access: offset +0 selects the low half, +4 the high half; the other half is untouched.
  - 4 B read returns the selected half zero-extended.
- Decode, mtime: 0xbff8 (8 B, or 4 B low half) and 0xbffc (4 B high half).
- Upper address bits must equal 0x0200 in addr[31:16], and addr[paddr_width_p-1:32] must be 0; otherwise the access is unmapped.
- Unmapped or misaligned access: write ignored; read data 0; resp_err_o=1; state unchanged.
- mtime tick: prescaler counts 0..rtc_div_p-1. When it reaches rtc_div_p-1, mtime increments by 1 (64-bit wrap to 0) and the prescaler returns to 0.
- A mtime write in the same cycle as a tick wins: the written value is stored and no increment is applied. The prescaler is not reset by mtime writes.
- timer_irq_o[h] is a registered compare of mtime >= mtimecmp[h] (unsigned), using post-update values. It rises 1 cycle after the condition holds and is level, not sticky: writing a larger mtimecmp clears it 1 cycle after the write.
- soft_irq_o[h] is registered directly from msip[h]; it changes the cycle after the write.
- Reset assertion mid-transaction aborts the pending response: resp_v_o falls asynchronously and no response is replayed.
- Hart index h >= num_core_p within the msip/mtimecmp windows is unmapped.

Test Plan:
- Reset check: after reset, read mtimecmp[0] (8 B at 0x0200_4000) -> resp_data_o=0xFFFF_FFFF_FFFF_FFFF, resp_err_o=0; timer_irq_o=0; soft_irq_o=0.
- Tick rate, rtc_div_p=8: idle 80 cycles after reset, then read mtime -> value 10 (±1 for read timing); an mtime write of 0xFFFF_FFFF_FFFF_FFFF followed by 8 cycles -> reads 0 (wrap).
- Timer IRQ: write mtimecmp[2]=20, wait -> timer_irq_o[2] rises 1 cycle after mtime reaches 20, other bits stay 0; write mtimecmp[2]=0xFFFF_FFFF -> bit clears next cycle.
- Software IRQ, 4 B half accesses: write msip[3]=1 -> soft_irq_o=4'b1000 next cycle. Write 4 B 0xDEAD_BEEF at 0x0200_4004 -> 8 B read of 0x0200_4000 returns 0xDEAD_BEEF_FFFF_FFFF.
- Errors: read 0x0200_4020 with num_core_p=4 -> data 0, err 1; 8 B access at 0x0200_4004 -> err 1; write 0x0300_0000 -> err 1, no state change.
- Handshake and collision:
  - Hold resp_yumi_i=0 for 5 cycles -> resp_v_o and data stable, req_ready_o=0.
  - mtime write of 100 in the tick cycle -> subsequent read returns 100 before the next tick.
  - Assert reset_n_i low in RESP -> resp_v_o=0 immediately, and all registers return to their reset values.

Source files
------------

// File: rtl/bp_clint_multi_if.sv
// Request/response channel between the I/O network and the CLINT.
interface bp_clint_multi_if #(
  parameter int unsigned paddr_width_p = 56,
  parameter int unsigned dword_width_p = 64
);
  logic                     req_v_i;
  logic                     req_ready_o;
  logic                     req_wr_i;
  logic [paddr_width_p-1:0] req_addr_i;
  logic                     req_size_i;
  logic [dword_width_p-1:0] req_data_i;
  logic                     resp_v_o;
  logic                     resp_yumi_i;
  logic [dword_width_p-1:0] resp_data_o;
  logic                     resp_err_o;

  modport master (
    output req_v_i, req_wr_i, req_addr_i, req_size_i, req_data_i, resp_yumi_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );

  modport slave (
    input  req_v_i, req_wr_i, req_addr_i, req_size_i, req_data_i, resp_yumi_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/bp_clint_multi.sv
// Multi-hart core-local interruptor: per-hart msip/mtimecmp, shared prescaled mtime.
module bp_clint_multi #(
  parameter int unsigned num_core_p    = 4,
  parameter int unsigned paddr_width_p = 56,
  parameter int unsigned dword_width_p = 64,
  parameter int unsigned rtc_div_p     = 8,
  localparam int unsigned rtc_div_width_lp = $clog2(rtc_div_p) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_clint_multi_if.slave       io,
  output logic [num_core_p-1:0] timer_irq_o,
  output logic [num_core_p-1:0] soft_irq_o
);

  localparam int unsigned hart_w_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam logic [15:0] msip_end_lp = 16'(4 * num_core_p);
  localparam logic [15:0] cmp_base_lp = 16'h4000;
  localparam logic [15:0] cmp_end_lp  = 16'(32'h4000 + 8 * num_core_p);
  localparam logic [15:0] mtime_lo_lp = 16'hbff8;
  localparam logic [15:0] mtime_hi_lp = 16'hbffc;

  typedef enum logic {st_idle, st_resp} state_e;

  state_e                      state_q, state_n;
  logic [63:0]                 mtime_q, mtime_n;
  logic [rtc_div_width_lp-1:0] presc_q, presc_n;
  logic [63:0]                 mtimecmp_q [num_core_p];
  logic [63:0]                 mtimecmp_n [num_core_p];
  logic [num_core_p-1:0]       msip_q, msip_n;
  logic [num_core_p-1:0]       timer_irq_q, timer_irq_n, soft_irq_q;
  logic [63:0]                 resp_data_q, resp_data_n;
  logic                        resp_err_q, resp_err_n;

  logic                        hs, tick, base_ok;
  logic [15:0]                 off;
  logic                        sel_msip, sel_cmp, sel_mtime, half, dec_err;
  logic [hart_w_lp-1:0]        msip_h, cmp_h;
  logic [63:0]                 wdata;

  // 4 B writes replace one half; 8 B writes replace the whole register
  function automatic logic [63:0] merge_w(input logic [63:0] old, input logic [63:0] wd,
                                          input logic full, input logic hi);
    if (full) return wd;
    if (hi) return {wd[31:0], old[31:0]};
    return {old[63:32], wd[31:0]};
  endfunction

  function automatic logic [63:0] select_r(input logic [63:0] val, input logic full,
                                           input logic hi);
    if (full) return val;
    if (hi) return {32'h0, val[63:32]};
    return {32'h0, val[31:0]};
  endfunction

  assign hs      = io.req_v_i && (state_q == st_idle);
  assign off     = io.req_addr_i[15:0];
  assign wdata   = 64'(io.req_data_i);
  assign base_ok = (io.req_addr_i[31:16] == 16'h0200) && ((io.req_addr_i >> 32) == '0);
  assign msip_h  = hart_w_lp'(off >> 2);
  assign cmp_h   = hart_w_lp'((off - cmp_base_lp) >> 3);
  assign tick    = (presc_q == rtc_div_width_lp'(rtc_div_p - 1));

  // Address decode; anything not selected is an error
  always_comb begin
    sel_msip  = 1'b0;
    sel_cmp   = 1'b0;
    sel_mtime = 1'b0;
    half      = 1'b0;
    if (base_ok) begin
      if (off < msip_end_lp) begin
        sel_msip = (off[1:0] == 2'b00) && !io.req_size_i;
      end else if (off >= cmp_base_lp && off < cmp_end_lp) begin
        sel_cmp = io.req_size_i ? (off[2:0] == 3'b000) : (off[1:0] == 2'b00);
        half    = off[2];
      end else if (off == mtime_lo_lp) begin
        sel_mtime = 1'b1;
      end else if (off == mtime_hi_lp) begin
        sel_mtime = !io.req_size_i;
        half      = 1'b1;
      end
    end
    dec_err = !(sel_msip || sel_cmp || sel_mtime);
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      st_idle: if (io.req_v_i)     state_n = st_resp;
      st_resp: if (io.resp_yumi_i) state_n = st_idle;
      default:                     state_n = st_idle;
    endcase
  end

  // Register updates; a same-cycle mtime write overrides the tick increment
  always_comb begin
    presc_n     = tick ? '0 : presc_q + rtc_div_width_lp'(1);
    mtime_n     = tick ? mtime_q + 64'd1 : mtime_q;
    msip_n      = msip_q;
    mtimecmp_n  = mtimecmp_q;
    resp_data_n = resp_data_q;
    resp_err_n  = resp_err_q;
    if (hs) begin
      resp_data_n = '0;
      resp_err_n  = dec_err;
      if (!dec_err && io.req_wr_i) begin
        if (sel_msip)  msip_n[msip_h]    = wdata[0];
        if (sel_cmp)   mtimecmp_n[cmp_h] = merge_w(mtimecmp_q[cmp_h], wdata, io.req_size_i, half);
        if (sel_mtime) mtime_n           = merge_w(mtime_q, wdata, io.req_size_i, half);
      end else if (!dec_err) begin
        if (sel_msip)  resp_data_n = 64'(msip_q[msip_h]);
        if (sel_cmp)   resp_data_n = select_r(mtimecmp_q[cmp_h], io.req_size_i, half);
        if (sel_mtime) resp_data_n = select_r(mtime_q, io.req_size_i, half);
      end
    end
    for (int h = 0; h < num_core_p; h++) begin
      timer_irq_n[h] = (mtime_n >= mtimecmp_n[h]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= st_idle;
      mtime_q     <= '0;
      presc_q     <= '0;
      msip_q      <= '0;
      timer_irq_q <= '0;
      soft_irq_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      for (int h = 0; h < num_core_p; h++) mtimecmp_q[h] <= '1;
    end else begin
      state_q     <= state_n;
      mtime_q     <= mtime_n;
      presc_q     <= presc_n;
      msip_q      <= msip_n;
      timer_irq_q <= timer_irq_n;
      soft_irq_q  <= msip_n;
      resp_data_q <= resp_data_n;
      resp_err_q  <= resp_err_n;
      for (int h = 0; h < num_core_p; h++) mtimecmp_q[h] <= mtimecmp_n[h];
    end
  end

  assign io.req_ready_o = (state_q == st_idle);
  assign io.resp_v_o    = (state_q == st_resp);
  assign io.resp_data_o = dword_width_p'(resp_data_q);
  assign io.resp_err_o  = resp_err_q;
  assign timer_irq_o    = timer_irq_q;
  assign soft_irq_o     = soft_irq_q;

endmodule
